// File: rtl/coreboard1588_pkg.sv
// Shared encodings for the Coreboard1588 timestamped capture engine.
package coreboard1588_pkg;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'd0,
        TRIG_EXTERNAL  = 2'd1,
        TRIG_TIME      = 2'd2,
        TRIG_RESERVED  = 2'd3
    } trig_src_e;

    localparam logic [7:0] REC_MAGIC = 8'hA5;
    localparam int         REC_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_GRANT = 3'd2,
        ST_WRITE = 3'd3,
        ST_DROP  = 3'd4
    } cap_state_e;

    function automatic logic [31:0] rec_header(input logic [7:0] ch, input logic [15:0] seq);
        return {REC_MAGIC, ch, seq};
    endfunction

endpackage

// File: rtl/coreboard1588_capture_if.sv
// Multi-channel AXI4-Stream sample bus feeding the capture engine.
interface coreboard1588_capture_if #(
    parameter int C_NUM_CH = 2
);
    logic [32*C_NUM_CH-1:0] tdata;
    logic [C_NUM_CH-1:0]    tvalid;
    logic [C_NUM_CH-1:0]    tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/coreboard1588_rr_arbiter.sv
// Round-robin arbiter; priority starts at the channel after the last accepted grant.
module coreboard1588_rr_arbiter
    import coreboard1588_pkg::*;
#(
    parameter int C_NUM_CH = 2,
    localparam int IDX_W = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [C_NUM_CH-1:0] req,
    input  logic                accept,
    output logic [C_NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx
);

    logic [IDX_W-1:0]    ptr;
    logic [C_NUM_CH-1:0] req_hi;
    logic [C_NUM_CH-1:0] pool;

    always_comb begin
        req_hi    = '0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            req_hi[i] = req[i] && (i >= int'(ptr));
        end
        // Requests at or above the pointer win; otherwise wrap to the lowest request.
        pool = (|req_hi) ? req_hi : req;
        for (int i = C_NUM_CH - 1; i >= 0; i--) begin
            if (pool[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_idx == IDX_W'(C_NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/coreboard1588_capture.sv
// Timestamped multi-channel sample capture into a ping-pong BRAM with per-bank interrupt.
//
// state | meaning
// IDLE  | session off, no tready; waits for ctrl_enable rising edge
// ARMED | waiting for trigger (immediate, ext edge, or rtc >= trigger time)
// GRANT | round-robin handshake of one sample from a masked channel
// WRITE | emitting the 4-word record, one word per cycle
// DROP  | current bank still full; masked samples accepted and discarded
module coreboard1588_capture
    import coreboard1588_pkg::*;
#(
    parameter int C_NUM_CH          = 2,
    parameter int C_BRAM_ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    coreboard1588_capture_if.slave       s_axis,
    input  logic [31:0]                  rtc_second,
    input  logic [31:0]                  rtc_nanosecond,
    input  logic                         ext_trigger,
    input  logic                         ctrl_enable,
    input  logic [C_NUM_CH-1:0]          ctrl_ch_mask,
    input  logic [1:0]                   ctrl_trigger_source,
    input  logic                         ctrl_trigger_edge,
    input  logic [31:0]                  ctrl_trigger_second,
    input  logic [31:0]                  ctrl_trigger_nanosecond,
    input  logic                         ctrl_irq_ack,
    output logic [C_BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic                         bram_en,
    output logic                         bram_we,
    output logic [31:0]                  bram_din,
    output logic                         irq,
    output logic [1:0]                   stat_bank_full,
    output logic                         stat_overflow,
    output logic [C_BRAM_ADDR_WIDTH-3:0] stat_fill
);

    localparam int IDX_W     = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
    localparam int REC_IDX_W = C_BRAM_ADDR_WIDTH - 3;

    cap_state_e                   state;
    logic                         enable_q;
    logic                         ext_s1, ext_s2, ext_s3;
    logic                         bank;
    logic                         last_set;
    logic [1:0]                   bank_full;
    logic [1:0]                   full_acked;
    logic [1:0]                   full_set;
    logic [15:0]                  seq;
    logic [C_BRAM_ADDR_WIDTH-3:0] fill;
    logic [1:0]                   word_cnt;
    logic [31:0]                  rec_sec, rec_ns, rec_data;
    logic                         overflow;

    logic [C_NUM_CH-1:0] req;
    logic [C_NUM_CH-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [C_NUM_CH-1:0] tready_c;
    logic [31:0]         sel_data;
    logic                handshake;
    logic                time_ge;
    logic                trig_fire;
    logic                last_rec;

    assign req       = s_axis.tvalid & ctrl_ch_mask;
    assign handshake = (state == ST_GRANT) && ctrl_enable && (|req);
    assign time_ge   = {rtc_second, rtc_nanosecond} >= {ctrl_trigger_second, ctrl_trigger_nanosecond};
    assign last_rec  = (fill[REC_IDX_W-1:0] == {REC_IDX_W{1'b1}});

    coreboard1588_rr_arbiter #(.C_NUM_CH(C_NUM_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .accept    (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        tready_c = '0;
        if (state == ST_GRANT && ctrl_enable) begin
            tready_c = grant;
        end else if (state == ST_DROP) begin
            tready_c = ctrl_ch_mask;
        end
    end
    assign s_axis.tready = tready_c;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (grant[i]) sel_data = s_axis.tdata[32*i +: 32];
        end
    end

    always_comb begin
        case (ctrl_trigger_source)
            TRIG_EXTERNAL: trig_fire = ctrl_trigger_edge ? (ext_s3 & ~ext_s2) : (ext_s2 & ~ext_s3);
            TRIG_TIME:     trig_fire = time_ge;
            default:       trig_fire = 1'b1;
        endcase
    end

    // Ack releases the oldest full bank; with both full the older is the one not set last.
    always_comb begin
        full_acked = bank_full;
        if (ctrl_irq_ack) begin
            case (bank_full)
                2'b01:   full_acked = 2'b00;
                2'b10:   full_acked = 2'b00;
                2'b11:   full_acked = last_set ? 2'b10 : 2'b01;
                default: full_acked = bank_full;
            endcase
        end
        full_set       = full_acked;
        full_set[bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            enable_q  <= 1'b0;
            ext_s1    <= 1'b0;
            ext_s2    <= 1'b0;
            ext_s3    <= 1'b0;
            bank      <= 1'b0;
            last_set  <= 1'b0;
            bank_full <= '0;
            irq       <= 1'b0;
            overflow  <= 1'b0;
            seq       <= '0;
            fill      <= '0;
            word_cnt  <= '0;
            rec_sec   <= '0;
            rec_ns    <= '0;
            rec_data  <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
        end else begin
            enable_q  <= ctrl_enable;
            ext_s1    <= ext_trigger;
            ext_s2    <= ext_s1;
            ext_s3    <= ext_s2;
            bank_full <= full_acked;
            irq       <= |full_acked;
            if (state == ST_DROP && |(tready_c & s_axis.tvalid)) overflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (ctrl_enable && !enable_q) begin
                        seq      <= '0;
                        overflow <= 1'b0;
                        fill     <= '0;
                        bank     <= 1'b0;
                        state    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!ctrl_enable)   state <= ST_IDLE;
                    else if (trig_fire) state <= full_acked[bank] ? ST_DROP : ST_GRANT;
                end
                ST_GRANT: begin
                    if (handshake) begin
                        rec_sec   <= rtc_second;
                        rec_ns    <= rtc_nanosecond;
                        rec_data  <= sel_data;
                        bram_addr <= {bank, fill[REC_IDX_W-1:0], 2'b00};
                        bram_din  <= rec_header(8'(grant_idx), seq);
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        word_cnt  <= 2'(REC_WORDS - 1);
                        state     <= ST_WRITE;
                    end else if (!ctrl_enable) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (word_cnt != 2'd0) begin
                        bram_addr <= bram_addr + 1'b1;
                        case (word_cnt)
                            2'd3:    bram_din <= rec_sec;
                            2'd2:    bram_din <= rec_ns;
                            default: bram_din <= rec_data;
                        endcase
                        word_cnt <= word_cnt - 1'b1;
                    end else begin
                        bram_en <= 1'b0;
                        bram_we <= 1'b0;
                        seq     <= seq + 1'b1;
                        if (last_rec) begin
                            bank_full <= full_set;
                            irq       <= 1'b1;
                            last_set  <= bank;
                            bank      <= ~bank;
                            fill      <= '0;
                        end else begin
                            fill <= fill + 1'b1;
                        end
                        if (!ctrl_enable)                      state <= ST_IDLE;
                        else if (last_rec && full_set[~bank]) state <= ST_DROP;
                        else                                   state <= ST_GRANT;
                    end
                end
                ST_DROP: begin
                    if (!ctrl_enable)           state <= ST_IDLE;
                    else if (!full_acked[bank]) state <= ST_GRANT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stat_bank_full = bank_full;
    assign stat_overflow  = overflow;
    assign stat_fill      = fill;

endmodule

// File: tb/tb_coreboard1588_capture.sv
// Directed bench for coreboard1588_capture with 2 channels and 4-record banks.
module tb_coreboard1588_capture;
    import coreboard1588_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 5;

    logic          clk;
    logic          rst;
    logic [31:0]   rtc_second, rtc_nanosecond;
    logic          ext_trigger, ctrl_enable;
    logic [NCH-1:0] ctrl_ch_mask;
    logic [1:0]    ctrl_trigger_source;
    logic          ctrl_trigger_edge;
    logic [31:0]   ctrl_trigger_second, ctrl_trigger_nanosecond;
    logic          ctrl_irq_ack;
    logic [AW-1:0] bram_addr;
    logic          bram_en, bram_we;
    logic [31:0]   bram_din;
    logic          irq;
    logic [1:0]    stat_bank_full;
    logic          stat_overflow;
    logic [AW-3:0] stat_fill;

    coreboard1588_capture_if #(.C_NUM_CH(NCH)) axis ();

    coreboard1588_capture #(.C_NUM_CH(NCH), .C_BRAM_ADDR_WIDTH(AW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_axis                  (axis.slave),
        .rtc_second              (rtc_second),
        .rtc_nanosecond          (rtc_nanosecond),
        .ext_trigger             (ext_trigger),
        .ctrl_enable             (ctrl_enable),
        .ctrl_ch_mask            (ctrl_ch_mask),
        .ctrl_trigger_source     (ctrl_trigger_source),
        .ctrl_trigger_edge       (ctrl_trigger_edge),
        .ctrl_trigger_second     (ctrl_trigger_second),
        .ctrl_trigger_nanosecond (ctrl_trigger_nanosecond),
        .ctrl_irq_ack            (ctrl_irq_ack),
        .bram_addr               (bram_addr),
        .bram_en                 (bram_en),
        .bram_we                 (bram_we),
        .bram_din                (bram_din),
        .irq                     (irq),
        .stat_bank_full          (stat_bank_full),
        .stat_overflow           (stat_overflow),
        .stat_fill               (stat_fill)
    );

    int          checks = 0;
    int          errors = 0;
    int          wcnt   = 0;
    int          base   = 0;
    logic [31:0] waddr_log [256];
    logic [31:0] wdata_log [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bram_en && bram_we && wcnt < 256) begin
            waddr_log[wcnt] = 32'(bram_addr);
            wdata_log[wcnt] = bram_din;
            wcnt = wcnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst                     = 1'b1;
        ctrl_enable             = 1'b0;
        axis.tvalid             = '0;
        ext_trigger             = 1'b0;
        ctrl_irq_ack            = 1'b0;
        ctrl_ch_mask            = '0;
        ctrl_trigger_source     = 2'd0;
        ctrl_trigger_edge       = 1'b0;
        ctrl_trigger_second     = '0;
        ctrl_trigger_nanosecond = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 base = wcnt;
    endtask

    task automatic wait_writes(input string tag, input int n);
        int k;
        k = 0;
        while ((wcnt - base) < n && k < 400) begin
            @(posedge clk);
            #1 k++;
        end
        chk(tag, 32'((wcnt - base) >= n), 32'd1);
    endtask

    task automatic pulse_ack();
        ctrl_irq_ack = 1'b1;
        @(posedge clk);
        #1 ctrl_irq_ack = 1'b0;
    endtask

    initial begin
        int k;
        axis.tdata     = {32'h2222_0001, 32'h1111_0000};
        rtc_second     = 32'd1;
        rtc_nanosecond = 32'd100;
        do_reset();

        // reset values
        chk("rst_tready", 32'(axis.tready), 32'd0);
        chk("rst_en", 32'(bram_en), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_din", bram_din, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_full", 32'(stat_bank_full), 32'd0);
        chk("rst_ovf", 32'(stat_overflow), 32'd0);
        chk("rst_fill", 32'(stat_fill), 32'd0);

        // immediate trigger, both channels valid: alternating grants
        ctrl_ch_mask = 2'b11;
        axis.tvalid  = 2'b11;
        ctrl_enable  = 1'b1;
        wait_writes("b_wait", 12);
        axis.tvalid = 2'b00;
        repeat (8) @(posedge clk);
        #1;
        chk("b_hdr0", wdata_log[base+0], 32'hA500_0000);
        chk("b_sec0", wdata_log[base+1], 32'd1);
        chk("b_ns0", wdata_log[base+2], 32'd100);
        chk("b_dat0", wdata_log[base+3], 32'h1111_0000);
        chk("b_hdr1", wdata_log[base+4], 32'hA501_0001);
        chk("b_addr4", waddr_log[base+4], 32'd4);
        chk("b_addr7", waddr_log[base+7], 32'd7);
        chk("b_dat1", wdata_log[base+7], 32'h2222_0001);
        chk("b_hdr2", wdata_log[base+8], 32'hA500_0002);
        chk("b_count", 32'(wcnt - base), 32'd12);
        chk("b_fill", 32'(stat_fill), 32'd3);

        // fill bank 0, then continue into bank 1
        axis.tvalid = 2'b11;
        wait_writes("c_wait16", 16);
        chk("c_full", 32'(stat_bank_full), 32'd1);
        chk("c_irq", 32'(irq), 32'd1);
        chk("c_fill", 32'(stat_fill), 32'd0);
        wait_writes("c_wait20", 20);
        chk("c_addr16", waddr_log[base+16], 32'd16);
        chk("c_hdr4", wdata_log[base+16], 32'hA500_0004);
        pulse_ack();
        chk("c_irq_ack", 32'(irq), 32'd0);
        chk("c_full_ack", 32'(stat_bank_full), 32'd0);
        axis.tvalid = 2'b00;
        repeat (8) @(posedge clk);
        #1;

        // both banks full without ack -> drop, then ack resumes at bank 0
        do_reset();
        ctrl_ch_mask = 2'b11;
        axis.tvalid  = 2'b11;
        ctrl_enable  = 1'b1;
        wait_writes("d_wait32", 32);
        repeat (6) @(posedge clk);
        #1;
        chk("d_full", 32'(stat_bank_full), 32'd3);
        chk("d_irq", 32'(irq), 32'd1);
        chk("d_ovf", 32'(stat_overflow), 32'd1);
        chk("d_tready", 32'(axis.tready), 32'd3);
        chk("d_count", 32'(wcnt - base), 32'd32);
        pulse_ack();
        chk("d_full_ack", 32'(stat_bank_full), 32'd2);
        wait_writes("d_wait33", 33);
        chk("d_addr_resume", waddr_log[base+32], 32'd0);
        chk("d_hdr_resume", wdata_log[base+32], 32'hA500_0008);
        axis.tvalid = 2'b00;
        repeat (6) @(posedge clk);
        #1;

        // time-compare trigger at 5 s / 100 ns
        do_reset();
        ctrl_trigger_source     = 2'd2;
        ctrl_trigger_second     = 32'd5;
        ctrl_trigger_nanosecond = 32'd100;
        ctrl_ch_mask            = 2'b01;
        axis.tvalid             = 2'b01;
        rtc_second              = 32'd5;
        for (int c = 0; c < 5; c++) begin
            rtc_nanosecond = 32'(97 + c);
            ctrl_enable    = 1'b1;
            @(negedge clk);
            chk($sformatf("e_tready_c%0d", c), 32'(axis.tready), (c == 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        axis.tvalid = 2'b00;
        wait_writes("e_wait", 4);
        chk("e_hdr", wdata_log[base+0], 32'hA500_0000);
        chk("e_sec", wdata_log[base+1], 32'd5);
        chk("e_ns", wdata_log[base+2], 32'd101);

        // external trigger, falling edge
        do_reset();
        ctrl_trigger_source = 2'd1;
        ctrl_trigger_edge   = 1'b1;
        ctrl_ch_mask        = 2'b01;
        axis.tvalid         = 2'b01;
        ctrl_enable         = 1'b1;
        repeat (4) @(posedge clk);
        #1 ext_trigger = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("f_rise_c%0d", c), 32'(axis.tready), 32'd0);
        end
        @(posedge clk);
        #1 ext_trigger = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("f_fall_c%0d", c), 32'(axis.tready), (c == 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        axis.tvalid = 2'b00;
        wait_writes("f_wait", 4);
        chk("f_hdr", wdata_log[base+0], 32'hA500_0000);

        // async reset mid-record at word k=2
        do_reset();
        ctrl_ch_mask = 2'b01;
        axis.tvalid  = 2'b01;
        ctrl_enable  = 1'b1;
        k = 0;
        while (!(bram_en && bram_addr == 5'd2) && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        chk("g_reach_k2", 32'(bram_en && bram_addr == 5'd2), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("g_en_async", 32'(bram_en), 32'd0);
        chk("g_addr_async", 32'(bram_addr), 32'd0);
        ctrl_enable = 1'b0;
        axis.tvalid = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("g_tready", 32'(axis.tready), 32'd0);
        chk("g_irq", 32'(irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
